mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the MIPS pipeline, directly downstream of `execution`. It takes the ALU result as an effective address, or as a pass-through value, together with store data and load/store control. It runs a req/ack transaction with data memory, performing byte-lane steering, load extraction and sign/zero extension, and presents one writeback record per accepted instruction. Upstream is stalled through `in_ready` while a memory transaction is outstanding.

## Interface
- `MAX_WAIT`, default 255: cycles `dmem_req` may stay high without `dmem_ack` before abort; legal range 1..255.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept.
- `alu_result` in 32: `execution` `d1_out`; address or pass-through value.
- `store_data` in 32: rt value for stores.
- `mem_read` in 1: load.
- `mem_write` in 1: store.
- `mem_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_unsigned` in 1: zero-extend loads (lbu/lhu).
- `rd_in` in 5: destination register.
- `reg_write` in 1: instruction writes rd.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write strobe.
- `dmem_addr` out 32: word address, bits [1:0] forced 0.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables, little-endian.
- `dmem_ack` in 1: transaction complete; rdata valid same cycle.
- `dmem_rdata` in 32: read word.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_data` out 32: writeback value.
- `wb_rd` out 5: writeback register.
- `wb_reg_write` out 1: commit enable.
- `timeout_err` out 1: one-cycle pulse on abort.
- `misalign_err` out 1: one-cycle pulse on misaligned access.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - WAIT: `in_ready`=0, `dmem_req`=1.
- Accept happens on `in_valid & in_ready`. All inputs are latched at accept.
- No memory op (`mem_read`=`mem_write`=0): stay IDLE. Next cycle `wb_valid`=1, `wb_data`=`alu_result`, `wb_reg_write`=`reg_write`.
- Memory op: go to WAIT. `dmem_addr`/`dmem_we`/`dmem_be`/`dmem_wdata` are registered and held constant until WAIT exits.
- If `mem_read` and `mem_write` are both 1, the write wins. `wb_reg_write`=0 and `wb_data`=`alu_result`.
- Byte enables, with a = addr[1:0]:
  - byte: `be`=0001<<a.
  - half: `be`=0011<<{a[1],0}.
  - word: `be`=1111.
- Store data is replicated: byte {4{sd[7:0]}}, half {2{sd[15:0]}}.
- Load extraction:
  - byte = rdata[8a+7:8a].
  - half = rdata[16a[1]+15:16a[1]].
  - Sign-extend unless `mem_unsigned`.
- `dmem_ack` sampled high in WAIT:
  - Leave to IDLE.
  - Next cycle `wb_valid`=1. For loads, `wb_data` is the extracted value and `wb_reg_write`=`reg_write`. For stores, `wb_reg_write`=0.
- `dmem_ack` while `dmem_req`=0 is ignored.
- Timeout:
  - The wait counter clears on WAIT entry and increments each WAIT cycle without ack.
  - After `MAX_WAIT` req-high cycles without ack: drop req, pulse `timeout_err`, `wb_valid`=1, `wb_reg_write`=0, return to IDLE.
  - Ack in the final allowed cycle completes normally.
- Reset:
  - All outputs reset to 0 except `in_ready`=1. State resets to IDLE and the counter to 0.
  - Reset in WAIT drops `dmem_req` at that edge with no writeback.

## Timing
- Pass-through: accept at cycle N → `wb_valid` at N+1. Back-to-back accepts every cycle.
- Memory op:
  - Accept at N → `dmem_req` high from N+1.
  - Ack sampled at M ≥ N+1 → `dmem_req` low and `wb_valid` at M+1. `in_ready` high at M+1, next accept at M+1.
  - Minimum load/store latency is 2 cycles. Minimum issue interval is 2 cycles.
- `wb_*` outputs are registered and valid for exactly one cycle. Writeback never back-pressures.
- `timeout_err`/`misalign_err` coincide with their `wb_valid` pulse.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half access with a[0]=1, or a word access with a≠0, issues no memory request and stays IDLE.
  - Next cycle `wb_valid`=1, `misalign_err`=1, `wb_reg_write`=0.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `misalign_err` is tied 0.
  - Misaligned half/word accesses use lane selection from a[1] (half) or no offset (word). The low offset bits are ignored and the access proceeds normally.

## Test plan
- Pass-through: `alu_result`=0x0000_1234, `reg_write`=1, `rd_in`=5 → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, with no `dmem_req`.
- lb sign vs lbu:
  - Addr 0x103, rdata 0x80FF_FFFF, ack one cycle after req → `dmem_be`=1000, `wb_data`=0xFFFF_FF80.
  - Same access with `mem_unsigned` → 0x0000_0080.
- sh: addr 0x202, `store_data`=0xAAAA_BEEF → `dmem_addr`=0x200, `dmem_be`=1100, `dmem_wdata`=0xBEEF_BEEF, `dmem_we`=1, `wb_reg_write`=0.
- Timeout: `MAX_WAIT`=4, no ack → `dmem_req` high exactly 4 cycles, then `timeout_err` and `wb_valid` pulse with `wb_reg_write`=0. A variant with ack on the 4th cycle completes normally.
- Misaligned lw at 0x101:
  - With `MEM_ALIGN_CHECK_EN`: no req, `misalign_err`=1 at N+1.
  - Without it: req to 0x100, `dmem_be`=1111.
- Reset mid-WAIT: assert `rst` on the 2nd req cycle → `dmem_req`=0, `wb_valid`=0, `in_ready`=1 after the edge. A later ack is ignored.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: req/ack data-memory transaction, byte-lane steering, load extension.
// Optional MEM_ALIGN_CHECK_EN makes misaligned half/word accesses fault instead of issuing.
module mem_access #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  rd_in,
    input  logic        reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        timeout_err,
    output logic        misalign_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;
    logic        regw_q, regw_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;

    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_regw_q, wb_regw_d;
    logic        tmo_q, tmo_d;
    logic        mis_q, mis_d;

    logic        accept;
    logic        mem_op;
    logic        misalign;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign accept = in_valid & (state_q == S_IDLE);
    assign mem_op = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op &
                      (((mem_size == 2'b01) & alu_result[0]) |
                       (mem_size[1] & (alu_result[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Lane steering for the outgoing request, computed from the accepting inputs.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = store_data;
        unique case (mem_size)
            2'b00: begin
                be_calc    = 4'b0001 << alu_result[1:0];
                wdata_calc = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_calc    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{store_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = store_data;
            end
        endcase
    end

    // Load extraction uses the offset captured at accept.
    always_comb begin
        byte_sel = 8'h00;
        unique case (off_q)
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (size_q)
            2'b00:   load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'b01:   load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_d      = alu_q;
        rd_d       = rd_q;
        regw_d     = regw_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        is_load_d  = is_load_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_regw_d  = 1'b0;
        tmo_d      = 1'b0;
        mis_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_d     = alu_result;
                    rd_d      = rd_in;
                    regw_d    = reg_write;
                    size_d    = mem_size;
                    uns_d     = mem_unsigned;
                    off_d     = alu_result[1:0];
                    is_load_d = mem_read & ~mem_write;
                    if (misalign) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd_in;
                        mis_d      = 1'b1;
                    end else if (mem_op) begin
                        state_d = S_WAIT;
                        cnt_d   = 8'd0;
                        addr_d  = {alu_result[31:2], 2'b00};
                        we_d    = mem_write;
                        be_d    = be_calc;
                        wdata_d = wdata_calc;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd_in;
                        wb_regw_d  = reg_write;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    state_d    = S_IDLE;
                    we_d       = 1'b0;
                    be_d       = 4'b0000;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (is_load_q) begin
                        wb_data_d = load_val;
                        wb_regw_d = regw_q;
                    end else begin
                        wb_data_d = alu_q;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    state_d    = S_IDLE;
                    we_d       = 1'b0;
                    be_d       = 4'b0000;
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_q;
                    wb_rd_d    = rd_q;
                    tmo_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            alu_q      <= 32'd0;
            rd_q       <= 5'd0;
            regw_q     <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            off_q      <= 2'd0;
            is_load_q  <= 1'b0;
            addr_q     <= 32'd0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            wb_regw_q  <= 1'b0;
            tmo_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            regw_q     <= regw_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            is_load_q  <= is_load_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_regw_q  <= wb_regw_d;
            tmo_q      <= tmo_d;
            mis_q      <= mis_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign dmem_req     = (state_q == S_WAIT);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_regw_q;
    assign timeout_err  = tmo_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access (MAX_WAIT=4); checks pass-through, loads, stores, timeout, reset.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [4:0]  rd_in;
    logic        reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        timeout_err;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail = 0;

    mem_access #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .rd_in(rd_in), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .timeout_err(timeout_err), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single accept edge, then deasserts.
    task automatic issue(input logic [31:0] a, input logic [31:0] sd,
                         input logic mr, input logic mw,
                         input logic [1:0] sz, input logic u,
                         input logic [4:0] rd, input logic rw);
        in_valid     = 1'b1;
        alu_result   = a;
        store_data   = sd;
        mem_read     = mr;
        mem_write    = mw;
        mem_size     = sz;
        mem_unsigned = u;
        rd_in        = rd;
        reg_write    = rw;
        step();
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        dmem_ack   = 1'b1;
        dmem_rdata = d;
        step();
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", dmem_req); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
        n_checks++; if (dmem_be !== 4'b0) begin n_fail++; $display("FAIL rst_be got %b want 0000", dmem_be); end
        n_checks++; if ({timeout_err, misalign_err, dmem_we} !== 3'b0) begin n_fail++; $display("FAIL rst_err got %b want 000", {timeout_err, misalign_err, dmem_we}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_passthrough();
        issue(32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5, 1'b1);
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL pt_wb_valid got %b want 1", wb_valid); end
        n_checks++; if (wb_data !== 32'h0000_1234) begin n_fail++; $display("FAIL pt_wb_data got %h want 00001234", wb_data); end
        n_checks++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL pt_wb_rd got %0d want 5", wb_rd); end
        n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL pt_regw got %b want 1", wb_reg_write); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL pt_req got %b want 0", dmem_req); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL pt_pulse got %b want 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid   = 1'b1;
        alu_result = 32'h0000_00AA;
        rd_in      = 5'd1;
        reg_write  = 1'b1;
        step();
        alu_result = 32'h0000_00BB;
        rd_in      = 5'd2;
        n_checks++; if (wb_data !== 32'hAA || wb_rd !== 5'd1) begin n_fail++; $display("FAIL b2b_first got %h/%0d want aa/1", wb_data, wb_rd); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hBB || wb_rd !== 5'd2) begin n_fail++; $display("FAIL b2b_second got %b/%h/%0d want 1/bb/2", wb_valid, wb_data, wb_rd); end
        step();
    endtask

    task automatic test_loads();
        issue(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd7, 1'b1);
        n_checks++; if (dmem_req !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_req got %b/%b want 1/0", dmem_req, in_ready); end
        n_checks++; if (dmem_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be got %b want 1000", dmem_be); end
        n_checks++; if (dmem_addr !== 32'h100 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL lb_addr got %h/%b want 100/0", dmem_addr, dmem_we); end
        ack(32'h80FF_FFFF);
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data got %b/%h want 1/ffffff80", wb_valid, wb_data); end
        n_checks++; if (wb_rd !== 5'd7 || wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL lb_rd got %0d/%b want 7/1", wb_rd, wb_reg_write); end
        n_checks++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_done got %b/%b want 0/1", dmem_req, in_ready); end
        issue(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd7, 1'b1);
        ack(32'h80FF_FFFF);
        n_checks++; if (wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data got %h want 00000080", wb_data); end
        issue(32'h0000_0102, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd8, 1'b1);
        n_checks++; if (dmem_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be got %b want 1100", dmem_be); end
        ack(32'h8001_1234);
        n_checks++; if (wb_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_data got %h want ffff8001", wb_data); end
        issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd8, 1'b1);
        ack(32'h8001_9234);
        n_checks++; if (wb_data !== 32'h0000_9234) begin n_fail++; $display("FAIL lhu_data got %h want 00009234", wb_data); end
    endtask

    task automatic test_stores();
        issue(32'h0000_0202, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd3, 1'b1);
        n_checks++; if (dmem_addr !== 32'h200 || dmem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_addr got %h/%b want 200/1100", dmem_addr, dmem_be); end
        n_checks++; if (dmem_wdata !== 32'hBEEF_BEEF || dmem_we !== 1'b1) begin n_fail++; $display("FAIL sh_wdata got %h/%b want beefbeef/1", dmem_wdata, dmem_we); end
        step();
        step();
        n_checks++; if (dmem_req !== 1'b1 || dmem_wdata !== 32'hBEEF_BEEF || dmem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_hold got %b/%h/%b want 1/beefbeef/1100", dmem_req, dmem_wdata, dmem_be); end
        ack(32'hDEAD_DEAD);
        n_checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'h202) begin n_fail++; $display("FAIL sh_wb got %b/%b/%h want 1/0/202", wb_valid, wb_reg_write, wb_data); end
        issue(32'h0000_0001, 32'h1234_5678, 1'b1, 1'b1, 2'b00, 1'b0, 5'd4, 1'b1);
        n_checks++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h7878_7878 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL sb_bus got %b/%h/%b want 0010/78787878/1", dmem_be, dmem_wdata, dmem_we); end
        ack(32'hFFFF_FFFF);
        n_checks++; if (wb_reg_write !== 1'b0 || wb_data !== 32'h1) begin n_fail++; $display("FAIL sb_wb got %b/%h want 0/1", wb_reg_write, wb_data); end
    endtask

    task automatic test_timeout();
        issue(32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dmem_req !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_req%0d got %b/%b want 1/0", i, dmem_req, wb_valid); end
            step();
        end
        n_checks++; if (dmem_req !== 1'b0 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_abort got %b/%b want 0/1", dmem_req, timeout_err); end
        n_checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL tmo_wb got %b/%b want 1/0", wb_valid, wb_reg_write); end
        step();
        n_checks++; if (timeout_err !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got %b/%b want 0/0", timeout_err, wb_valid); end
        issue(32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1);
        step();
        step();
        step();
        ack(32'h1122_3344);
        n_checks++; if (timeout_err !== 1'b0 || wb_data !== 32'h1122_3344 || wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL tmo_last_ack got %b/%h/%b want 0/11223344/1", timeout_err, wb_data, wb_reg_write); end
    endtask

    task automatic test_misalign();
        issue(32'h0000_0101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd10, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
        n_checks++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mis_noreq got %b/%b want 0/1", dmem_req, in_ready); end
        n_checks++; if (misalign_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL mis_err got %b/%b/%b want 1/1/0", misalign_err, wb_valid, wb_reg_write); end
        step();
`else
        n_checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin n_fail++; $display("FAIL mis_req got %b/%h/%b want 1/100/1111", dmem_req, dmem_addr, dmem_be); end
        ack(32'hCAFE_F00D);
        n_checks++; if (wb_data !== 32'hCAFE_F00D || misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_data got %h/%b want cafef00d/0", wb_data, misalign_err); end
`endif
    endtask

    task automatic test_reset_wait();
        issue(32'h0000_0080, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd11, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_state got %b/%b/%b want 0/0/1", dmem_req, wb_valid, in_ready); end
        ack(32'h5555_5555);
        n_checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rstw_late_ack got %b/%b want 0/0", wb_valid, dmem_req); end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        alu_result   = 32'h0;
        store_data   = 32'h0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        rd_in        = 5'd0;
        reg_write    = 1'b0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_loads();
        test_stores();
        test_timeout();
        test_misalign();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
